irq_request_ctrl: RTL and testbench
===================================

Name: irq_request_ctrl

Overview:
- Interrupt request front end that sits directly upstream of the 8:3 priority encoder.
- Captures eight raw request lines into a pending register, with per-line edge or level detection, and applies a software-writable enable mask.
- Drives the masked pending vector into the encoder and registers the winning index.
- Presents that index to the consumer with a valid/ack handshake; ack clears the served pending bit.

Parameters:
- EDGE_SEL, 8'h00: per-line detect mode. Bit k = 1 makes line k rising-edge detected; bit k = 0 makes it level detected.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  8  raw request lines. Already synchronous to clk.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  8  new mask value. Bit = 1 enables the line.
- irq_ack  in  1  consumer acknowledge. Only honoured while irq_valid = 1.
- mask  out  8  current mask register.
- pending  out  8  current pending register, unmasked.
- irq_valid  out  1  irq_id holds a serviceable request.
- irq_id  out  3  index of the highest-priority masked pending line. Line 7 has the highest priority.

Behaviour:
- Reset (rst = 1 at a posedge): pending = 0, mask = 0, req_d = 0, state = IDLE, irq_valid = 0, irq_id = 0. Reset overrides every other event, including ack and mask_we in the same cycle.
- Reset mid-handshake drops irq_valid after that edge. No ack is required.
- req_d is a registered copy of req. Because req_d resets to 0, an edge line already high at the first post-reset edge counts as an edge.
- Set vector: set[k] = EDGE_SEL[k] ? (req[k] & ~req_d[k]) : req[k].
- Clear vector: clr = onehot(irq_id) when state = ASSERT and irq_ack = 1, else 0.
- Update every edge: pending <= (pending & ~clr) | set. Set wins when set and clear hit the same bit, so a level line still high re-pends immediately.
- Mask: mask <= mask_wdata on the edge where mask_we = 1. masked = pending & mask.
- Encoder hookup: encoder i = masked, en = 1 (tied high), so its output is never Z.
- any = |masked. An index of 0 is ambiguous on its own; only `any` qualifies a grant.
- FSM state IDLE:
  - irq_valid = 0.
  - If any = 1: irq_id <= encoder y, state <= ASSERT.
  - Otherwise stay in IDLE; irq_id holds.
- FSM state ASSERT:
  - irq_valid = 1; irq_id is held stable.
  - If irq_ack = 1: clear pending[irq_id], state <= IDLE.
  - Otherwise stay in ASSERT.
  - A mask change or a higher-priority arrival does not retract or retarget the grant.
- Latency: req sampled at edge E0 → pending bit set after E0 → irq_valid = 1 after E1 (2 cycles).
- Ack sampled at Ek → irq_valid = 0 after Ek. The next grant appears after Ek+1, so there is a minimum one-cycle low gap between grants.
- irq_ack while IDLE is ignored and clears nothing.
- Masking a pending line keeps its pending bit. Unmasking it later makes it eligible on the next IDLE evaluation.
- Edge line: repeated edges while already pending coalesce into one pending bit.

Decomposition:
- Shared package: N_IRQ = 8, IDX_W = 3, the state encoding (IDLE = 1'b0, ASSERT = 1'b1), and a onehot8 decode function.
- One sub-module: the existing 8:3 priority_encoder, instanced as-is with en tied to 1'b1. No new encoder logic.

Test Plan:
1. Reset then idle:
   - Stimulus: rst high 2 cycles, req = 8'hFF, mask = 0.
   - Required: irq_valid = 0 throughout; pending = 8'hFF after the first post-reset edge.
2. Priority and latency:
   - Stimulus: mask = 8'hFF, EDGE_SEL = 0, req = 8'b0010_0100 from E0.
   - Required: irq_valid = 1, irq_id = 5 after E1.
   - Ack, with req[5] dropped → irq_id = 2 two edges after the ack; valid low exactly one cycle in between.
3. Index 0 boundary:
   - Stimulus: mask = 8'h01, req[0] pulse.
   - Required: irq_valid = 1, irq_id = 0. With masked = 0, irq_valid stays 0.
4. Edge mode:
   - Stimulus: EDGE_SEL = 8'h80, req[7] held high 5 cycles.
   - Required: exactly one grant with id 7. After ack, pending[7] = 0 while req[7] stays high.
5. Hold and simultaneity:
   - Stimulus: in ASSERT with id 3, assert req[6] and write mask = 0.
   - Required: id stays 3 and valid stays 1 until ack.
   - Level line 3 still high on the ack edge → pending[3] = 1 afterwards.
6. Reset mid-ASSERT:
   - Stimulus: irq_valid = 1, rst pulse with irq_ack = 1.
   - Required: irq_valid = 0, pending = 0, mask = 0 after that edge.

Source files
------------

// File: rtl/irq_request_ctrl_pkg.sv
// Shared widths, FSM state encoding and one-hot decode for the interrupt request front end.
package irq_request_ctrl_pkg;

  localparam int unsigned N_IRQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    StIdle   = 1'b0,
    StAssert = 1'b1
  } state_e;

  function automatic logic [N_IRQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_IRQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/irq_request_ctrl_priority_encoder.sv
// 8:3 priority encoder; line 7 has the highest priority, output is 0 when disabled or idle.
module priority_encoder
  import irq_request_ctrl_pkg::*;
(
  input  logic [N_IRQ-1:0] i,
  input  logic             en,
  output logic [IDX_W-1:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      // Ascending scan so the highest set line is the last one written.
      for (int k = 0; k < N_IRQ; k++) begin
        if (i[k]) begin
          y = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request front end: pending capture, enable mask, priority pick and valid/ack handoff.
module irq_request_ctrl
  import irq_request_ctrl_pkg::*;
#(
  parameter logic [N_IRQ-1:0] EDGE_SEL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] req,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             irq_ack,
  output logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] pending,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_id
);

  state_e           state_q;
  logic [N_IRQ-1:0] req_d_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;
  logic             irq_valid_q;
  logic [IDX_W-1:0] irq_id_q;

  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] clr_vec;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] pending_d;
  logic [IDX_W-1:0] enc_y;
  logic             any;

  always_comb begin
    set_vec   = (EDGE_SEL & req & ~req_d_q) | (~EDGE_SEL & req);
    clr_vec   = (state_q == StAssert && irq_ack) ? onehot8(irq_id_q) : '0;
    // Set is OR-ed last so a still-active level line re-pends on its own ack edge.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    masked    = pending_q & mask_q;
    any       = |masked;
  end

  priority_encoder u_enc (
    .i  (masked),
    .en (1'b1),
    .y  (enc_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_d_q     <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      req_d_q   <= req;
      pending_q <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      unique case (state_q)
        StIdle: begin
          if (any) begin
            irq_id_q    <= enc_y;
            irq_valid_q <= 1'b1;
            state_q     <= StAssert;
          end
        end
        StAssert: begin
          // Grant is held until ack; mask writes and new arrivals do not retarget it.
          if (irq_ack) begin
            irq_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          irq_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign mask      = mask_q;
  assign pending   = pending_q;
  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Directed vector table plus hand sequences for irq_request_ctrl with line 7 edge-detected.
module tb_irq_request_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = 8'h00;
  logic       irq_ack = 1'b0;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       irq_valid;
  logic [2:0] irq_id;

  int checks = 0;
  int failures = 0;

  irq_request_ctrl #(
    .EDGE_SEL (8'h80)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .mask       (mask),
    .pending    (pending),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       we;
    logic [7:0] wd;
    logic       ack;
    logic       valid;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] mask;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] q, input logic w, input logic [7:0] wd,
                     input logic a, input logic v, input logic [2:0] id, input logic [7:0] p,
                     input logic [7:0] m);
    vec_t t;
    t.rst = r; t.req = q; t.we = w; t.wd = wd; t.ack = a;
    t.valid = v; t.id = id; t.pend = p; t.mask = m;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] q, input logic w, input logic [7:0] wd,
                       input logic a);
    rst = r; req = q; mask_we = w; mask_wdata = wd; irq_ack = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //   rst req    we wd     ack valid id pend   mask
    // Reset then idle with everything requesting but masked off
    add(1, 8'hFF, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    add(1, 8'hFF, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'hFF, 0, 8'h00, 0, 0, 0, 8'hFF, 8'h00);
    add(0, 8'hFF, 0, 8'h00, 0, 0, 0, 8'hFF, 8'h00);
    // Priority and latency
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'h00, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 0, 0, 0, 8'h24, 8'hFF);
    add(0, 8'h24, 0, 8'h00, 0, 1, 5, 8'h24, 8'hFF);
    add(0, 8'h04, 0, 8'h00, 1, 0, 5, 8'h04, 8'hFF);
    add(0, 8'h04, 0, 8'h00, 0, 1, 2, 8'h04, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 1, 0, 2, 8'h00, 8'hFF);
    add(0, 8'h00, 0, 8'h00, 0, 0, 2, 8'h00, 8'hFF);
    // Index 0 boundary, then masked-off line and ack while idle
    add(0, 8'h01, 1, 8'h01, 0, 0, 2, 8'h01, 8'h01);
    add(0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h01, 8'h01);
    add(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'h01);
    add(0, 8'h02, 0, 8'h00, 0, 0, 0, 8'h02, 8'h01);
    add(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h02, 8'h01);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h02, 8'h01);
    // Edge line 7 held high five cycles: one grant only
    add(0, 8'h80, 1, 8'h80, 0, 0, 0, 8'h82, 8'h80);
    add(0, 8'h80, 0, 8'h00, 0, 1, 7, 8'h82, 8'h80);
    add(0, 8'h80, 0, 8'h00, 0, 1, 7, 8'h82, 8'h80);
    add(0, 8'h80, 0, 8'h00, 1, 0, 7, 8'h02, 8'h80);
    add(0, 8'h80, 0, 8'h00, 0, 0, 7, 8'h02, 8'h80);
    add(0, 8'h00, 0, 8'h00, 0, 0, 7, 8'h02, 8'h80);
    // Hold under higher-priority arrival and mask clear; level re-pend on ack
    add(0, 8'h08, 1, 8'hFF, 0, 0, 7, 8'h0A, 8'hFF);
    add(0, 8'h08, 0, 8'h00, 0, 1, 3, 8'h0A, 8'hFF);
    add(0, 8'h48, 1, 8'h00, 0, 1, 3, 8'h4A, 8'h00);
    add(0, 8'h48, 0, 8'h00, 0, 1, 3, 8'h4A, 8'h00);
    add(0, 8'h48, 0, 8'h00, 1, 0, 3, 8'h4A, 8'h00);
    add(0, 8'h48, 0, 8'h00, 0, 0, 3, 8'h4A, 8'h00);
    // Reset mid-ASSERT with ack and mask write in the same cycle
    add(0, 8'h48, 1, 8'hFF, 0, 0, 3, 8'h4A, 8'hFF);
    add(0, 8'h48, 0, 8'h00, 0, 1, 6, 8'h4A, 8'hFF);
    add(1, 8'h48, 1, 8'hAA, 1, 0, 0, 8'h00, 8'h00);
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].req, vecs[k].we, vecs[k].wd, vecs[k].ack);
      tick();
      chk($sformatf("v%0d_valid", k), int'(irq_valid), int'(vecs[k].valid));
      chk($sformatf("v%0d_id", k), int'(irq_id), int'(vecs[k].id));
      chk($sformatf("v%0d_pending", k), int'(pending), int'(vecs[k].pend));
      chk($sformatf("v%0d_mask", k), int'(mask), int'(vecs[k].mask));
    end

    // Repeated edges on line 7 coalesce into one pending bit and one grant
    drive(0, 8'h80, 0, 8'h00, 0); tick();
    drive(0, 8'h00, 0, 8'h00, 0); tick();
    drive(0, 8'h80, 0, 8'h00, 0); tick();
    drive(0, 8'h00, 0, 8'h00, 0); tick();
    chk("coalesce_pending", int'(pending), 8'h80);
    chk("coalesce_masked_valid", int'(irq_valid), 0);
    drive(0, 8'h00, 1, 8'h80, 0); tick();
    chk("coalesce_unmask_edge", int'(irq_valid), 0);
    drive(0, 8'h00, 0, 8'h00, 0); tick();
    chk("coalesce_grant_valid", int'(irq_valid), 1);
    chk("coalesce_grant_id", int'(irq_id), 7);
    drive(0, 8'h00, 0, 8'h00, 1); tick();
    chk("coalesce_ack_pending", int'(pending), 8'h00);
    drive(0, 8'h00, 0, 8'h00, 0); tick();
    tick();
    chk("coalesce_no_second_grant", int'(irq_valid), 0);

    // Bounded wait for a grant: two edges from request to valid
    drive(0, 8'h10, 1, 8'hFF, 0); tick();
    drive(0, 8'h10, 0, 8'h00, 0);
    n = 1;
    while (!irq_valid && n < 10) begin
      tick();
      n++;
    end
    chk("latency_edges", n, 2);
    chk("latency_id", int'(irq_id), 4);
    drive(0, 8'h10, 0, 8'h00, 1); tick();
    chk("relevel_gap_valid", int'(irq_valid), 0);
    chk("relevel_pending", int'(pending), 8'h10);
    drive(0, 8'h00, 0, 8'h00, 0); tick();
    chk("relevel_regrant_valid", int'(irq_valid), 1);
    chk("relevel_regrant_id", int'(irq_id), 4);
    drive(0, 8'h00, 0, 8'h00, 1); tick();
    chk("final_valid", int'(irq_valid), 0);
    chk("final_pending", int'(pending), 8'h00);
    drive(0, 8'h00, 0, 8'h00, 0); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
